// File: rtl/tile_config_mem_shadowed_if.sv
// Column frame bus and tile configuration outputs of tile_config_mem_shadowed.
// The master side drives frames and commit requests; the slave side is the memory.
interface tile_config_mem_shadowed_if #(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NoConfigBits    = 640
);
    localparam int SelW   = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1;
    localparam int CountW = $clog2(MaxFramesPerCol + 1);

    logic [FrameBitsPerRow-1:0] FrameData;
    logic [MaxFramesPerCol-1:0] FrameStrobe;
    logic                       Commit;
    logic                       CommitForce;
    logic [SelW-1:0]            ReadbackSel;
    logic [FrameBitsPerRow-1:0] ReadbackData;
    logic [NoConfigBits-1:0]    ConfigBits;
    logic [NoConfigBits-1:0]    ConfigBits_N;
    logic [CountW-1:0]          FramesWritten;
    logic                       AllWritten;
    logic                       Busy;
    logic                       CommitError;
    logic                       StrobeError;

    modport master (
        output FrameData, FrameStrobe, Commit, CommitForce, ReadbackSel,
        input  ReadbackData, ConfigBits, ConfigBits_N, FramesWritten, AllWritten,
               Busy, CommitError, StrobeError
    );

    modport slave (
        input  FrameData, FrameStrobe, Commit, CommitForce, ReadbackSel,
        output ReadbackData, ConfigBits, ConfigBits_N, FramesWritten, AllWritten,
               Busy, CommitError, StrobeError
    );
endinterface

// File: rtl/tile_config_mem_shadowed.sv
// Shadowed tile configuration memory: frames land in a shadow bank and are
// copied into the active ConfigBits in one edge by a commit handshake.
module tile_config_mem_shadowed #(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NoConfigBits    = 640,
    parameter int EmulationEn     = 0,
    parameter logic [MaxFramesPerCol*FrameBitsPerRow-1:0] Emulate_Bitstream = '0
) (
    input logic CLK,
    input logic resetn,
    tile_config_mem_shadowed_if.slave bus
);
    localparam int TotalBits    = MaxFramesPerCol * FrameBitsPerRow;
    localparam int NeededFrames = (NoConfigBits + FrameBitsPerRow - 1) / FrameBitsPerRow;
    localparam int CountW       = $clog2(MaxFramesPerCol + 1);
    localparam logic [CountW-1:0] NeededCount = CountW'(NeededFrames);
    localparam logic [NoConfigBits-1:0] ActiveReset =
        (EmulationEn != 0) ? Emulate_Bitstream[NoConfigBits-1:0] : '0;

    typedef enum logic [1:0] {IDLE = 2'd0, COPY = 2'd1, CLEAR = 2'd2} state_t;

    function automatic logic isOneHot(input logic [MaxFramesPerCol-1:0] v);
        return (v != '0) && ((v & (v - MaxFramesPerCol'(1))) == '0);
    endfunction

    function automatic logic [CountW-1:0] countNeeded(input logic [MaxFramesPerCol-1:0] mask);
        logic [CountW-1:0] n;
        n = '0;
        for (int i = 0; i < NeededFrames; i++) begin
            n = n + CountW'(mask[i]);
        end
        return n;
    endfunction

    state_t                     state_r, stateNext_s;
    logic [FrameBitsPerRow-1:0] shadow_r [MaxFramesPerCol];
    logic [MaxFramesPerCol-1:0] writtenMask_r, maskNext_s, strobeQ_r, rise_s;
    logic [TotalBits-1:0]       shadowFlat_s;
    logic [NoConfigBits-1:0]    active_r;
    logic [FrameBitsPerRow-1:0] readback_r;
    logic [CountW-1:0]          framesWritten_r;
    logic                       allWritten_r, busy_r, commitError_r, strobeError_r;
    logic                       idle_s, doCopy_s, doClear_s, commitAccept_s, commitReject_s;
    logic                       writeOk_s, multiRise_s, strobeErrSet_s;

    // FSM state register.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) state_r <= IDLE;
        else         state_r <= stateNext_s;
    end

    // FSM next-state logic.
    always_comb begin
        stateNext_s = state_r;
        case (state_r)
            IDLE: begin
                if (commitAccept_s) stateNext_s = COPY;
                else                stateNext_s = IDLE;
            end
            COPY:    stateNext_s = CLEAR;
            CLEAR:   stateNext_s = IDLE;
            default: stateNext_s = IDLE;
        endcase
    end

    // FSM outputs: commit decision in IDLE, copy and clear strobes in the busy states.
    always_comb begin
        idle_s         = 1'b0;
        doCopy_s       = 1'b0;
        doClear_s      = 1'b0;
        commitAccept_s = 1'b0;
        commitReject_s = 1'b0;
        case (state_r)
            IDLE: begin
                idle_s = 1'b1;
                if (bus.Commit) begin
                    if (allWritten_r || bus.CommitForce) commitAccept_s = 1'b1;
                    else                                 commitReject_s = 1'b1;
                end else begin
                    commitAccept_s = 1'b0;
                end
            end
            COPY:    doCopy_s  = 1'b1;
            CLEAR:   doClear_s = 1'b1;
            default: idle_s    = 1'b0;
        endcase
    end

    // Strobe edge detection and frame-write qualification.
    always_comb begin
        rise_s         = bus.FrameStrobe & ~strobeQ_r;
        multiRise_s    = (rise_s != '0) && !isOneHot(rise_s);
        writeOk_s      = idle_s && isOneHot(rise_s);
        strobeErrSet_s = (rise_s != '0) && (!idle_s || multiRise_s);
        if (doClear_s)      maskNext_s = '0;
        else if (writeOk_s) maskNext_s = writtenMask_r | rise_s;
        else                maskNext_s = writtenMask_r;
    end

    // Shadow bank viewed as one flat vector in ConfigBits bit order.
    always_comb begin
        shadowFlat_s = '0;
        for (int f = 0; f < MaxFramesPerCol; f++) begin
            shadowFlat_s[f*FrameBitsPerRow +: FrameBitsPerRow] = shadow_r[f];
        end
    end

    // Shadow bank capture on a single qualified strobe rise.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            for (int f = 0; f < MaxFramesPerCol; f++) shadow_r[f] <= '0;
        end else if (writeOk_s) begin
            for (int f = 0; f < MaxFramesPerCol; f++) begin
                if (rise_s[f]) shadow_r[f] <= bus.FrameData;
            end
        end
    end

    // Active bank: whole-image copy so the tile never sees a partial update.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn)       active_r <= ActiveReset;
        else if (doCopy_s) active_r <= shadowFlat_s[NoConfigBits-1:0];
    end

    // Registered readback of one shadow frame; out-of-range selects read zero.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn)                                       readback_r <= '0;
        else if (int'(bus.ReadbackSel) < MaxFramesPerCol) readback_r <= shadow_r[bus.ReadbackSel];
        else                                               readback_r <= '0;
    end

    // Write tracking, status flags and strobe history.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            strobeQ_r       <= '0;
            writtenMask_r   <= '0;
            framesWritten_r <= '0;
            allWritten_r    <= 1'b0;
            busy_r          <= 1'b0;
            commitError_r   <= 1'b0;
            strobeError_r   <= 1'b0;
        end else begin
            strobeQ_r       <= bus.FrameStrobe;
            writtenMask_r   <= maskNext_s;
            framesWritten_r <= countNeeded(maskNext_s);
            allWritten_r    <= (countNeeded(maskNext_s) == NeededCount);
            busy_r          <= (stateNext_s != IDLE);
            commitError_r   <= commitReject_s;
            // A fresh error in the clearing cycle is kept rather than lost.
            if (strobeErrSet_s) strobeError_r <= 1'b1;
            else if (doClear_s) strobeError_r <= 1'b0;
        end
    end

    assign bus.ReadbackData  = readback_r;
    assign bus.ConfigBits    = active_r;
    assign bus.ConfigBits_N  = ~active_r;
    assign bus.FramesWritten = framesWritten_r;
    assign bus.AllWritten    = allWritten_r;
    assign bus.Busy          = busy_r;
    assign bus.CommitError   = commitError_r;
    assign bus.StrobeError   = strobeError_r;
endmodule

// File: tb/tb_tile_config_mem_shadowed.sv
// Scoreboard bench for tile_config_mem_shadowed: stimulus queues expected
// readback words and commit images, a negedge monitor pops and compares them.
module tb_tile_config_mem_shadowed;
    localparam int MF = 20;
    localparam int FB = 32;
    localparam int NC = 640;
    localparam logic [NC-1:0] EmuImage = {20{32'hAAAA_AAAA}};

    logic CLK = 1'b0;
    logic resetn;
    int   errors = 0;
    int   checks = 0;

    logic [FB-1:0] shadowM [MF];
    logic [NC-1:0] activeM;
    logic [FB-1:0] rbQ [$];
    logic [NC-1:0] cfgQ [$];
    logic          rbReq = 1'b0;
    logic          rbValidQ = 1'b0;

    tile_config_mem_shadowed_if #(.MaxFramesPerCol(MF), .FrameBitsPerRow(FB), .NoConfigBits(NC)) bus ();
    tile_config_mem_shadowed_if #(.MaxFramesPerCol(MF), .FrameBitsPerRow(FB), .NoConfigBits(NC)) busEmu ();

    tile_config_mem_shadowed #(.MaxFramesPerCol(MF), .FrameBitsPerRow(FB), .NoConfigBits(NC),
                               .EmulationEn(0)) dut (.CLK(CLK), .resetn(resetn), .bus(bus));
    tile_config_mem_shadowed #(.MaxFramesPerCol(MF), .FrameBitsPerRow(FB), .NoConfigBits(NC),
                               .EmulationEn(1), .Emulate_Bitstream(EmuImage))
        dutEmu (.CLK(CLK), .resetn(resetn), .bus(busEmu));

    always #5 CLK = ~CLK;

    always @(posedge CLK) rbValidQ <= rbReq;

    task automatic check(input string name, input logic [NC-1:0] act, input logic [NC-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NC-1:0] flatten();
        logic [NC-1:0] v;
        for (int f = 0; f < MF; f++) v[f*FB +: FB] = shadowM[f];
        return v;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic writeFrame(input int f, input logic [FB-1:0] d);
        bus.FrameData   = d;
        bus.FrameStrobe = MF'(1) << f;
        tick();
        bus.FrameStrobe = '0;
        shadowM[f]      = d;
        tick();
    endtask

    task automatic readback(input int sel, input logic [FB-1:0] exp);
        bus.ReadbackSel = 5'(sel);
        rbReq = 1'b1;
        rbQ.push_back(exp);
        tick();
        rbReq = 1'b0;
        tick();
    endtask

    task automatic sampleFw(input string name, input int fw, input logic aw);
        @(negedge CLK);
        check({name, "_fw"}, NC'(bus.FramesWritten), NC'(fw));
        check({name, "_aw"}, NC'(bus.AllWritten), NC'(aw));
        tick();
    endtask

    task automatic doCommit(input logic force_, input logic accept);
        logic [NC-1:0] newActive;
        bus.Commit      = 1'b1;
        bus.CommitForce = force_;
        tick();
        bus.Commit      = 1'b0;
        bus.CommitForce = 1'b0;
        @(negedge CLK);
        if (accept) begin
            check("busy_k", NC'(bus.Busy), NC'(1'b1));
            check("cfg_hold_k", bus.ConfigBits, activeM);
            check("cerr_k", NC'(bus.CommitError), NC'(1'b0));
            newActive = flatten();
            cfgQ.push_back(newActive);
            @(negedge CLK);
            check("cfg_k1", bus.ConfigBits, newActive);
            check("busy_k1", NC'(bus.Busy), NC'(1'b1));
            @(negedge CLK);
            check("busy_k2", NC'(bus.Busy), NC'(1'b0));
            check("fw_cleared", NC'(bus.FramesWritten), NC'(0));
            activeM = newActive;
        end else begin
            check("cerr_pulse", NC'(bus.CommitError), NC'(1'b1));
            check("busy_rej", NC'(bus.Busy), NC'(1'b0));
            @(negedge CLK);
            check("cerr_end", NC'(bus.CommitError), NC'(1'b0));
            check("cfg_unchanged", bus.ConfigBits, activeM);
        end
        tick();
    endtask

    // Scoreboard monitor: readback one cycle after a request, commit image when Busy falls.
    initial begin : monitor
        logic prevBusy;
        logic [NC-1:0] exp;
        prevBusy = 1'b0;
        forever begin
            @(negedge CLK);
            if (rbValidQ) begin
                if (rbQ.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL readback_unexpected: got %0h expected no data", bus.ReadbackData);
                end else begin
                    check("readback", NC'(bus.ReadbackData), NC'(rbQ.pop_front()));
                end
            end
            if (resetn && prevBusy && !bus.Busy) begin
                if (cfgQ.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL commit_unexpected: got completion expected none");
                end else begin
                    exp = cfgQ.pop_front();
                    check("commit_cfg", bus.ConfigBits, exp);
                    check("commit_cfg_n", bus.ConfigBits_N, ~exp);
                end
            end
            prevBusy = bus.Busy;
        end
    end

    initial begin
        bus.FrameData = '0; bus.FrameStrobe = '0; bus.Commit = 1'b0;
        bus.CommitForce = 1'b0; bus.ReadbackSel = '0;
        busEmu.FrameData = '0; busEmu.FrameStrobe = '0; busEmu.Commit = 1'b0;
        busEmu.CommitForce = 1'b0; busEmu.ReadbackSel = '0;
        for (int f = 0; f < MF; f++) shadowM[f] = '0;
        activeM = '0;
        resetn  = 1'b0;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_cfg", bus.ConfigBits, '0);
        check("rst_cfg_n", bus.ConfigBits_N, '1);
        check("rst_busy", NC'(bus.Busy), NC'(1'b0));
        check("rst_fw", NC'(bus.FramesWritten), NC'(0));
        check("rst_serr", NC'(bus.StrobeError), NC'(1'b0));
        check("rst_rb", NC'(bus.ReadbackData), NC'(0));
        check("emu_cfg", busEmu.ConfigBits, EmuImage);
        check("emu_cfg_n", busEmu.ConfigBits_N, ~EmuImage);
        @(posedge CLK); #1;
        resetn = 1'b1;
        tick();

        // Full image, then a normal commit.
        writeFrame(0, 32'h1000_0000);
        sampleFw("first", 1, 1'b0);
        for (int f = 1; f < MF; f++) writeFrame(f, 32'h1000_0000 + 32'(f));
        sampleFw("all", 20, 1'b1);
        readback(19, 32'h1000_0013);
        doCommit(1'b0, 1'b1);
        @(negedge CLK);
        check("cfg_lo", NC'(bus.ConfigBits[31:0]), NC'(32'h1000_0000));
        check("cfg_hi", NC'(bus.ConfigBits[639:608]), NC'(32'h1000_0013));
        tick();

        // Partial image: rejected without force, accepted with it.
        for (int f = 0; f < 5; f++) writeFrame(f, 32'h2000_0000 + 32'(f));
        sampleFw("partial", 5, 1'b0);
        doCommit(1'b0, 1'b0);
        doCommit(1'b1, 1'b1);

        // Held strobe writes only once.
        bus.FrameStrobe = MF'(1) << 3;
        for (int i = 0; i < 5; i++) begin
            bus.FrameData = 32'h3000_0000 + 32'(i);
            tick();
        end
        bus.FrameStrobe = '0;
        shadowM[3] = 32'h3000_0000;
        tick();
        readback(3, 32'h3000_0000);
        sampleFw("held", 1, 1'b0);

        // Two simultaneous rises: no write, sticky error until next commit.
        bus.FrameData   = 32'hDEAD_BEEF;
        bus.FrameStrobe = MF'(6);
        tick();
        bus.FrameStrobe = '0;
        tick();
        @(negedge CLK);
        check("serr_set", NC'(bus.StrobeError), NC'(1'b1));
        tick();
        sampleFw("multi", 1, 1'b0);
        readback(1, 32'h2000_0001);
        readback(2, 32'h2000_0002);
        readback(25, 32'h0);
        writeFrame(0, 32'h4000_0000);
        @(negedge CLK);
        check("serr_sticky", NC'(bus.StrobeError), NC'(1'b1));
        tick();
        sampleFw("after_multi", 2, 1'b0);
        doCommit(1'b1, 1'b1);
        @(negedge CLK);
        check("serr_cleared", NC'(bus.StrobeError), NC'(1'b0));
        tick();

        // Reset while in COPY.
        writeFrame(5, 32'h5555_5555);
        bus.Commit = 1'b1; bus.CommitForce = 1'b1;
        tick();
        bus.Commit = 1'b0; bus.CommitForce = 1'b0;
        resetn = 1'b0;
        #1;
        check("midrst_busy", NC'(bus.Busy), NC'(1'b0));
        check("midrst_cfg", bus.ConfigBits, '0);
        check("midrst_cfg_n", bus.ConfigBits_N, '1);
        check("midrst_fw", NC'(bus.FramesWritten), NC'(0));
        check("midrst_rb", NC'(bus.ReadbackData), NC'(0));
        @(posedge CLK); #1;
        resetn = 1'b1;
        for (int f = 0; f < MF; f++) shadowM[f] = '0;
        activeM = '0;
        tick();
        readback(5, 32'h0);
        readback(0, 32'h0);
        @(negedge CLK);
        check("post_rst_cfg", bus.ConfigBits, '0);
        check("post_rst_busy", NC'(bus.Busy), NC'(1'b0));

        checks++;
        if (rbQ.size() != 0 || cfgQ.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d readback %0d commit pending expected 0 0",
                     rbQ.size(), cfgQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
